// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: issues one instruction to an external 8-bit ALU, writes back result/flags.
// Optional macro ALU_EXEC_PIPE_EN: accept the next instruction while in DONE (1 instruction per 2 cycles).
module alu_exec_ctrl #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [3:0]    instr_mode,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_rs,
    input  logic [7:0]    instr_imm,
    input  logic          instr_use_imm,
    input  logic          instr_wb,
    output logic [7:0]    alu_op1,
    output logic [7:0]    alu_op2,
    output logic          alu_enable,
    output logic [3:0]    alu_mode,
    output logic [3:0]    alu_current_flags,
    input  logic [7:0]    alu_out,
    input  logic [3:0]    alu_flags,
    output logic [3:0]    flags,
    output logic [7:0]    result,
    output logic          done,
    input  logic [AW-1:0] dbg_addr,
    output logic [7:0]    dbg_data
);
    localparam int NREG = 1 << AW;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    regs_q [NREG];
    logic [7:0]    regs_d [NREG];
    logic [3:0]    flags_q, flags_d;
    logic [7:0]    result_q, result_d;
    logic [7:0]    op1_q, op1_d;
    logic [7:0]    op2_q, op2_d;
    logic [3:0]    mode_q, mode_d;
    logic [AW-1:0] rd_q, rd_d;
    logic          wb_q, wb_d;
    logic          accept;
    logic          carry_from_alu;

    always_comb begin
`ifdef ALU_EXEC_PIPE_EN
        instr_ready = (state_q == IDLE) || (state_q == DONE);
`else
        instr_ready = (state_q == IDLE);
`endif
        accept = instr_valid && instr_ready;
    end

    // Only arithmetic/shift modes produce a meaningful carry; the rest keep the old one.
    always_comb begin
        case (mode_q)
            4'h0, 4'h1, 4'h7, 4'h8, 4'h9, 4'hF: carry_from_alu = 1'b1;
            default:                             carry_from_alu = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        regs_d   = regs_q;
        flags_d  = flags_q;
        result_d = result_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        mode_d   = mode_q;
        rd_d     = rd_q;
        wb_d     = wb_q;

        if (accept) begin
            op1_d  = regs_q[instr_rd];
            op2_d  = instr_use_imm ? instr_imm : regs_q[instr_rs];
            mode_d = instr_mode;
            rd_d   = instr_rd;
            wb_d   = instr_wb;
        end

        case (state_q)
            IDLE: begin
                if (accept) state_d = EXEC;
            end
            EXEC: begin
                result_d = alu_out;
                flags_d  = {alu_flags[3],
                            carry_from_alu ? alu_flags[2] : flags_q[2],
                            alu_flags[1:0]};
                if (wb_q) regs_d[rd_q] = alu_out;
                state_d = DONE;
            end
            DONE: begin
                state_d = accept ? EXEC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            flags_q  <= '0;
            result_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            mode_q   <= '0;
            rd_q     <= '0;
            wb_q     <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            result_q <= result_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            mode_q   <= mode_d;
            rd_q     <= rd_d;
            wb_q     <= wb_d;
            regs_q   <= regs_d;
        end
    end

    always_comb begin
        alu_op1           = op1_q;
        alu_op2           = op2_q;
        alu_mode          = mode_q;
        alu_enable        = (state_q == EXEC);
        alu_current_flags = flags_q;
        flags             = flags_q;
        result            = result_q;
        done              = (state_q == DONE);
        dbg_data          = regs_q[dbg_addr];
    end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl with a behavioural ALU and an architectural reference model.
`timescale 1ns/1ps
module tb_alu_exec_ctrl;
    localparam int AW = 2;
`ifdef ALU_EXEC_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [3:0]    instr_mode = '0;
    logic [AW-1:0] instr_rd = '0;
    logic [AW-1:0] instr_rs = '0;
    logic [7:0]    instr_imm = '0;
    logic          instr_use_imm = 1'b0;
    logic          instr_wb = 1'b0;
    logic [7:0]    alu_op1, alu_op2, alu_out, result, dbg_data;
    logic          alu_enable, done;
    logic [3:0]    alu_mode, alu_current_flags, alu_flags, flags;
    logic [AW-1:0] dbg_addr = '0;

    int checks = 0;
    int failures = 0;

    logic [7:0] ref_regs [4];
    logic [3:0] ref_flags;
    logic [7:0] ref_result;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_mode(instr_mode), .instr_rd(instr_rd), .instr_rs(instr_rs),
        .instr_imm(instr_imm), .instr_use_imm(instr_use_imm), .instr_wb(instr_wb),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_enable(alu_enable),
        .alu_mode(alu_mode), .alu_current_flags(alu_current_flags),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .flags(flags), .result(result), .done(done),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Behavioural ALU; non-carry modes drive a deliberately arbitrary c.
    function automatic logic [11:0] alu_model(input logic [3:0] m, input logic [7:0] a,
                                              input logic [7:0] b, input logic cin);
        logic [8:0] w;
        logic [7:0] y;
        logic       c, o;
        w = '0;
        y = '0;
        o = 1'b0;
        c = ~(a[0] ^ b[0]);
        case (m)
            4'h0: begin w = {1'b0, a} + {1'b0, b}; y = w[7:0]; c = w[8];
                        o = (a[7] == b[7]) && (y[7] != a[7]); end
            4'h1: begin y = a - b; c = (a >= b); o = (a[7] != b[7]) && (y[7] != a[7]); end
            4'h2: y = a | b;
            4'h3: y = b;
            4'h4: y = a & b;
            4'h5: y = a ^ b;
            4'h6: y = ~a;
            4'h7: begin w = {1'b0, a} + {1'b0, b} + {8'b0, cin}; y = w[7:0]; c = w[8]; end
            4'h8: begin y = {a[6:0], 1'b0}; c = a[7]; end
            4'h9: begin y = {1'b0, a[7:1]}; c = a[0]; end
            4'hF: begin w = {1'b0, a} + 9'd1; y = w[7:0]; c = w[8]; end
            default: y = a + b;
        endcase
        return {(y == 8'h00), c, y[7], o, y};
    endfunction

    assign {alu_flags, alu_out} = alu_model(alu_mode, alu_op1, alu_op2, alu_current_flags[2]);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = AW'(i);
            #1;
            chk($sformatf("%s_r%0d", tag, i), dbg_data, ref_regs[i]);
        end
    endtask

    task automatic dbg_is(input string tag, input int idx, input logic [7:0] exp);
        dbg_addr = AW'(idx);
        #1;
        chk(tag, dbg_data, exp);
    endtask

    // Architectural effect of one instruction, from the controller's rules.
    task automatic ref_exec(input logic [3:0] m, input logic [AW-1:0] rd, input logic [7:0] b,
                            input logic wb, output logic [7:0] a_out);
        logic [11:0] r;
        a_out = ref_regs[rd];
        r = alu_model(m, ref_regs[rd], b, ref_flags[2]);
        ref_result = r[7:0];
        ref_flags[3] = r[11];
        ref_flags[1:0] = r[9:8];
        if (m inside {4'h0, 4'h1, 4'h7, 4'h8, 4'h9, 4'hF}) ref_flags[2] = r[10];
        if (wb) ref_regs[rd] = r[7:0];
    endtask

    task automatic issue(input logic [3:0] m, input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                         input logic [7:0] imm, input logic ui, input logic wb);
        logic [7:0] a, b;
        int t;
        t = 0;
        while (!instr_ready && t < 10) begin @(negedge clk); t++; end
        chk("ready_before_issue", instr_ready, 1);
        instr_mode = m; instr_rd = rd; instr_rs = rs; instr_imm = imm;
        instr_use_imm = ui; instr_wb = wb; instr_valid = 1'b1;
        b = ui ? imm : ref_regs[rs];
        @(negedge clk);
        // EXEC: offer a garbage instruction that must be ignored
        instr_mode = 4'($urandom); instr_rd = AW'($urandom); instr_rs = AW'($urandom);
        instr_imm = 8'($urandom); instr_use_imm = 1'($urandom); instr_wb = 1'b1;
        instr_valid = 1'b1;
        ref_exec(m, rd, b, wb, a);
        chk("exec_enable", alu_enable, 1);
        chk("exec_op1", alu_op1, a);
        chk("exec_op2", alu_op2, b);
        chk("exec_mode", alu_mode, m);
        chk("exec_done_low", done, 0);
        chk("exec_ready_low", instr_ready, 0);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_enable_low", alu_enable, 0);
        chk("done_ready", instr_ready, PIPE);
        chk("result", result, ref_result);
        chk("flags", flags, ref_flags);
        chk("cur_flags", alu_current_flags, ref_flags);
        check_regs("wb");
        @(negedge clk);
        chk("idle_done_low", done, 0);
        chk("idle_ready", instr_ready, 1);
    endtask

    initial begin
        int acc, dn, dn_total, prev_done, back2back;
        logic [7:0] tmp;
        for (int i = 0; i < 4; i++) ref_regs[i] = '0;
        ref_flags = '0;
        ref_result = '0;

        repeat (2) @(negedge clk);
        chk("rst_enable", alu_enable, 0);
        chk("rst_op1", alu_op1, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_regs("reset");
        chk("reset_flags", flags, 4'b0000);
        chk("reset_result", result, 8'h00);
        chk("reset_ready", instr_ready, 1);
        chk("reset_done", done, 0);
        chk("reset_mode", alu_mode, 0);

        // Reset landing in EXEC must cancel the instruction entirely
        instr_mode = 4'h3; instr_rd = 2'd2; instr_imm = 8'h55; instr_use_imm = 1'b1;
        instr_wb = 1'b1; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("midrst_in_exec", alu_enable, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_enable", alu_enable, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 3; i++) begin
            if (done) dn++;
            @(negedge clk);
        end
        chk("midrst_no_done", dn, 0);
        chk("midrst_ready", instr_ready, 1);
        chk("midrst_flags", flags, 0);
        dbg_is("midrst_r2", 2, 8'h00);

        issue(4'h3, 2'd0, 2'd0, 8'hF0, 1'b1, 1'b1);
        dbg_is("plan_r0_load", 0, 8'hF0);
        chk("plan_flags_load0", flags, 4'b0010);
        issue(4'h3, 2'd1, 2'd0, 8'h20, 1'b1, 1'b1);
        dbg_is("plan_r1_load", 1, 8'h20);
        chk("plan_flags_load1", flags, 4'b0000);
        issue(4'h0, 2'd0, 2'd1, 8'h00, 1'b0, 1'b1);
        chk("plan_add_result", result, 8'h10);
        chk("plan_add_flags", flags, 4'b0100);
        issue(4'h4, 2'd0, 2'd0, 8'h01, 1'b1, 1'b1);
        dbg_is("plan_and_r0", 0, 8'h00);
        chk("plan_and_flags", flags, 4'b1100);
        issue(4'h1, 2'd1, 2'd0, 8'h20, 1'b1, 1'b0);
        dbg_is("plan_cmp_r1", 1, 8'h20);
        chk("plan_cmp_result", result, 8'h00);
        chk("plan_cmp_flags", flags, 4'b1100);
        issue(4'h0, 2'd3, 2'd0, 8'hFF, 1'b1, 1'b1);
        issue(4'h0, 2'd3, 2'd0, 8'h01, 1'b1, 1'b1);
        dbg_is("wrap_r3", 3, 8'h00);

        for (int n = 0; n < 40; n++)
            issue(4'($urandom), AW'($urandom), AW'($urandom), 8'($urandom),
                  1'($urandom), ($urandom_range(0, 3) != 0));

        // Hold one instruction valid for 6 cycles
        instr_mode = 4'h3; instr_rd = 2'd3; instr_imm = 8'h5A; instr_use_imm = 1'b1;
        instr_wb = 1'b1; instr_valid = 1'b1;
        acc = 0; dn = 0; prev_done = 0; back2back = 0;
        for (int i = 0; i < 6; i++) begin
            if (instr_valid && instr_ready) acc++;
            if (done) begin dn++; if (prev_done != 0) back2back++; end
            prev_done = int'(done);
            @(negedge clk);
        end
        instr_valid = 1'b0;
        dn_total = dn;
        for (int i = 0; i < 3; i++) begin
            if (done) begin dn_total++; if (prev_done != 0) back2back++; end
            prev_done = int'(done);
            @(negedge clk);
        end
        ref_exec(4'h3, 2'd3, 8'h5A, 1'b1, tmp);
        chk("hold_accepts", acc, PIPE ? 3 : 2);
        chk("hold_done_window", dn, 2);
        chk("hold_done_per_instr", dn_total, acc);
        chk("hold_no_double_done", back2back, 0);
        chk("hold_flags", flags, ref_flags);
        check_regs("hold");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
